// File: rtl/cpu_writeback.sv
// Writeback stage: in-order result FIFO feeding the 8x8 register file byte port and HL pair port.
// Optional forwarding lookup is enabled by defining WB_FWD_EN.
module cpu_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_res_valid,
  output logic        o_res_ready,
  input  logic        i_res_pair,
  input  logic [2:0]  i_res_sel,
  input  logic [15:0] i_res_data,
  output logic        o_reg_wr_en,
  output logic [2:0]  o_reg_wr_sel,
  output logic [7:0]  o_reg_wr_data,
  output logic        o_hl_wr_en,
  output logic [15:0] o_hl_wr_data,
  output logic [7:0]  o_pending,
  output logic        o_idle,
  input  logic [2:0]  i_fwd_sel,
  output logic        o_fwd_hit,
  output logic [7:0]  o_fwd_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HI, S_LO} state_t;

  state_t state, cur_state;

  logic [DEPTH-1:0] pair_q;
  logic [2:0]       sel_q  [DEPTH];
  logic [15:0]      data_q [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, push, pop;
  logic             head_pair, head_split;
  logic [2:0]       head_sel;
  logic [15:0]      head_data;
  logic [7:0]       pending;

  function automatic logic [2:0] hi_reg(input logic [1:0] p);
    case (p)
      2'd0:    hi_reg = 3'd0;
      2'd1:    hi_reg = 3'd2;
      2'd2:    hi_reg = 3'd4;
      default: hi_reg = 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] lo_reg(input logic [1:0] p);
    case (p)
      2'd0:    lo_reg = 3'd1;
      2'd1:    lo_reg = 3'd3;
      2'd2:    lo_reg = 3'd5;
      default: lo_reg = 3'd6;
    endcase
  endfunction

  // F only holds the upper flag nibble, so the low byte of AF is masked
  function automatic logic [7:0] lo_val(input logic [1:0] p, input logic [15:0] d);
    lo_val = (p == 2'd3) ? {d[7:4], 4'h0} : d[7:0];
  endfunction

  assign full       = (count == DEPTH[AW:0]);
  assign empty      = (count == '0);
  assign head_pair  = pair_q[rd_ptr];
  assign head_sel   = sel_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign head_split = head_pair && (head_sel[1:0] != 2'd2);

  // S_HI is decoded in the same cycle a split pair reaches the head, so no bubble
  always_comb begin
    cur_state = state;
    if (state == S_IDLE && !empty && head_split) cur_state = S_HI;
  end

  assign push        = i_res_valid && !full;
  assign pop         = !empty && (cur_state != S_HI);
  assign o_res_ready = !full;
  assign o_idle      = empty && (state == S_IDLE);
  assign o_pending   = pending;

  always_comb begin
    o_reg_wr_en   = 1'b0;
    o_reg_wr_sel  = 3'd0;
    o_reg_wr_data = 8'h00;
    o_hl_wr_en    = 1'b0;
    o_hl_wr_data  = 16'h0000;
    if (!empty) begin
      case (cur_state)
        S_IDLE: begin
          if (head_pair) begin
            o_hl_wr_en   = 1'b1;
            o_hl_wr_data = head_data;
          end else begin
            o_reg_wr_en   = 1'b1;
            o_reg_wr_sel  = head_sel;
            o_reg_wr_data = head_data[7:0];
          end
        end
        S_HI: begin
          o_reg_wr_en   = 1'b1;
          o_reg_wr_sel  = hi_reg(head_sel[1:0]);
          o_reg_wr_data = head_data[15:8];
        end
        default: begin
          o_reg_wr_en   = 1'b1;
          o_reg_wr_sel  = lo_reg(head_sel[1:0]);
          o_reg_wr_data = lo_val(head_sel[1:0], head_data);
        end
      endcase
    end
  end

  // The head pair in S_LO has already committed its high register
  always_comb begin
    logic [AW-1:0] idx;
    pending = 8'h00;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + k[AW-1:0];
      if (k < int'(count)) begin
        if (pair_q[idx]) begin
          if (!(k == 0 && state == S_LO)) pending[hi_reg(sel_q[idx][1:0])] = 1'b1;
          pending[lo_reg(sel_q[idx][1:0])] = 1'b1;
        end else begin
          pending[sel_q[idx]] = 1'b1;
        end
      end
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match left standing is the youngest write
  always_comb begin
    logic [AW-1:0] idx;
    o_fwd_hit  = pending[i_fwd_sel];
    o_fwd_data = 8'h00;
    idx        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + k[AW-1:0];
      if (k < int'(count)) begin
        if (pair_q[idx]) begin
          if (!(k == 0 && state == S_LO) && hi_reg(sel_q[idx][1:0]) == i_fwd_sel)
            o_fwd_data = data_q[idx][15:8];
          if (lo_reg(sel_q[idx][1:0]) == i_fwd_sel)
            o_fwd_data = lo_val(sel_q[idx][1:0], data_q[idx]);
        end else if (sel_q[idx] == i_fwd_sel) begin
          o_fwd_data = data_q[idx][7:0];
        end
      end
    end
  end
`else
  logic unused_fwd_sel;
  assign unused_fwd_sel = ^i_fwd_sel;
  assign o_fwd_hit      = 1'b0;
  assign o_fwd_data     = 8'h00;
`endif

  always_ff @(posedge i_clk) begin
    if (push) begin
      pair_q[wr_ptr] <= i_res_pair;
      sel_q[wr_ptr]  <= i_res_sel;
      data_q[wr_ptr] <= i_res_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      state <= (cur_state == S_HI) ? S_LO : S_IDLE;
    end
  end

endmodule

// File: tb/tb_cpu_writeback.sv
// Self-checking bench for cpu_writeback: a queue of pending register-file writes models the stage.
// Define WB_FWD_EN for both the bench and the design to exercise forwarding.
module tb_cpu_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, valid, pair;
  logic [2:0]  sel, fwd_sel;
  logic [15:0] data;
  logic        res_ready, reg_wr_en, hl_wr_en, idle, fwd_hit;
  logic [2:0]  reg_wr_sel;
  logic [7:0]  reg_wr_data, pending, fwd_data;
  logic [15:0] hl_wr_data;

  always #5 clk = ~clk;

  cpu_writeback #(.DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_res_valid(valid), .o_res_ready(res_ready),
    .i_res_pair(pair), .i_res_sel(sel), .i_res_data(data),
    .o_reg_wr_en(reg_wr_en), .o_reg_wr_sel(reg_wr_sel), .o_reg_wr_data(reg_wr_data),
    .o_hl_wr_en(hl_wr_en), .o_hl_wr_data(hl_wr_data), .o_pending(pending), .o_idle(idle),
    .i_fwd_sel(fwd_sel), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data)
  );

  // One element per register-file write still owed; 'last' marks the final write of a result
  typedef struct {
    bit          hl;
    logic [2:0]  r;
    logic [7:0]  v;
    logic [15:0] w;
    bit          last;
  } op_t;

  op_t opq[$];
  int  total = 0;
  int  bad   = 0;
  bit  armed = 1'b0;

  logic [2:0] hi_tab [4] = '{3'd0, 3'd2, 3'd4, 3'd7};
  logic [2:0] lo_tab [4] = '{3'd1, 3'd3, 3'd5, 3'd6};

  function automatic int entries();
    int n = 0;
    foreach (opq[i]) if (opq[i].last) n++;
    return n;
  endfunction

  function automatic void model_push(input logic p, input logic [2:0] s, input logic [15:0] d);
    op_t o;
    o = '{hl: 1'b0, r: 3'd0, v: 8'h00, w: 16'h0000, last: 1'b1};
    if (!p) begin
      o.r = s; o.v = d[7:0];
      opq.push_back(o);
    end else if (s[1:0] == 2'd2) begin
      o.hl = 1'b1; o.w = d;
      opq.push_back(o);
    end else begin
      o.r = hi_tab[s[1:0]]; o.v = d[15:8]; o.last = 1'b0;
      opq.push_back(o);
      o.r = lo_tab[s[1:0]]; o.last = 1'b1;
      o.v = (s[1:0] == 2'd3) ? (d[7:0] & 8'hF0) : d[7:0];
      opq.push_back(o);
    end
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] m = 8'h00;
    foreach (opq[i]) begin
      if (opq[i].hl) m[5:4] = 2'b11;
      else m[opq[i].r] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [8:0] model_fwd(input logic [2:0] s);
    logic [8:0] r = 9'h000;
    foreach (opq[i]) begin
      if (opq[i].hl && s == 3'd4) r = {1'b1, opq[i].w[15:8]};
      else if (opq[i].hl && s == 3'd5) r = {1'b1, opq[i].w[7:0]};
      else if (!opq[i].hl && opq[i].r == s) r = {1'b1, opq[i].v};
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic p, input logic [2:0] s, input logic [15:0] d);
    valid = v; pair = p; sel = s; data = d;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    bit accept;
    if (rst) begin
      opq.delete();
    end else begin
      accept = entries() < DEPTH;
      if (opq.size() > 0) void'(opq.pop_front());
      if (valid && accept) model_push(pair, sel, data);
    end
  end

  always @(negedge clk) begin : compare
    logic [8:0] f;
    if (armed) begin
      checkOutput("ready", {15'd0, res_ready}, {15'd0, entries() < DEPTH});
      checkOutput("idle", {15'd0, idle}, {15'd0, opq.size() == 0});
      checkOutput("pending", {8'd0, pending}, {8'd0, model_pending()});
      checkOutput("reg_en", {15'd0, reg_wr_en}, {15'd0, opq.size() > 0 && !opq[0].hl});
      checkOutput("hl_en", {15'd0, hl_wr_en}, {15'd0, opq.size() > 0 && opq[0].hl});
      if (opq.size() > 0 && !opq[0].hl) begin
        checkOutput("reg_sel", {13'd0, reg_wr_sel}, {13'd0, opq[0].r});
        checkOutput("reg_data", {8'd0, reg_wr_data}, {8'd0, opq[0].v});
      end
      if (opq.size() > 0 && opq[0].hl)
        checkOutput("hl_data", hl_wr_data, opq[0].w);
`ifdef WB_FWD_EN
      f = model_fwd(fwd_sel);
`else
      f = 9'h000;
`endif
      checkOutput("fwd_hit", {15'd0, fwd_hit}, {15'd0, f[8]});
      checkOutput("fwd_data", {8'd0, fwd_data}, {8'd0, f[7:0]});
    end
  end

  initial begin
    rst = 1'b1; fwd_sel = 3'd7;
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    step();
    armed = 1'b1;
    step();
    rst = 1'b0;
    step();
    checkOutput("rst_pending", {8'd0, pending}, 16'h0000);
    checkOutput("rst_ready", {15'd0, res_ready}, 16'h0001);
    checkOutput("rst_idle", {15'd0, idle}, 16'h0001);
    checkOutput("rst_strobes", {14'd0, reg_wr_en, hl_wr_en}, 16'h0000);

    // byte write to A
    applyStimulus(1'b1, 1'b0, 3'd7, 16'h003C);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("byte_en", {15'd0, reg_wr_en}, 16'h0001);
    checkOutput("byte_sel", {13'd0, reg_wr_sel}, 16'h0007);
    checkOutput("byte_data", {8'd0, reg_wr_data}, 16'h003C);
    checkOutput("byte_pending", {8'd0, pending}, 16'h0080);
    step();
    checkOutput("byte_done_en", {15'd0, reg_wr_en}, 16'h0000);
    checkOutput("byte_done_pending", {8'd0, pending}, 16'h0000);

    // DE pair
    applyStimulus(1'b1, 1'b1, 3'd1, 16'h1234);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("de_hi", {5'd0, reg_wr_sel, reg_wr_data}, 16'h0212);
    checkOutput("de_hi_pending", {8'd0, pending}, 16'h000C);
    step();
    checkOutput("de_lo", {5'd0, reg_wr_sel, reg_wr_data}, 16'h0334);
    checkOutput("de_lo_pending", {8'd0, pending}, 16'h0008);
    step();

    // AF pair, F low nibble masked
    applyStimulus(1'b1, 1'b1, 3'd3, 16'hABCD);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("af_hi", {5'd0, reg_wr_sel, reg_wr_data}, 16'h07AB);
    step();
    checkOutput("af_lo", {5'd0, reg_wr_sel, reg_wr_data}, 16'h06C0);
    step();

    // HL pair through the wide port; sel[2] is ignored for pairs
    applyStimulus(1'b1, 1'b1, 3'd6, 16'hBEEF);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("hl_en", {14'd0, hl_wr_en, reg_wr_en}, 16'h0002);
    checkOutput("hl_data", hl_wr_data, 16'hBEEF);
    checkOutput("hl_pending", {8'd0, pending}, 16'h0030);
    step();
    checkOutput("hl_done_pending", {8'd0, pending}, 16'h0000);

    // BC pairs pushed every cycle fill the FIFO since they drain at half rate
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b1, 3'd0, 16'h1000 * k[15:0] + 16'h0011 * k[15:0]);
      step();
      if (k == 5) checkOutput("full_ready", {15'd0, res_ready}, 16'h0000);
      if (k == 6) checkOutput("ready_after_pop", {15'd0, res_ready}, 16'h0001);
      if (k == 7) checkOutput("full_again", {15'd0, res_ready}, 16'h0000);
    end
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    repeat (9) step();
    checkOutput("drained_idle", {15'd0, idle}, 16'h0001);

    // reset in the middle of a pair leaves it half-written
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h5566);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("mid_hi", {5'd0, reg_wr_sel, reg_wr_data}, 16'h0055);
    step();
    checkOutput("mid_lo", {5'd0, reg_wr_sel, reg_wr_data}, 16'h0166);
    checkOutput("mid_lo_pending", {8'd0, pending}, 16'h0002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("mid_rst_strobes", {14'd0, reg_wr_en, hl_wr_en}, 16'h0000);
    checkOutput("mid_rst_idle", {15'd0, idle}, 16'h0001);
    checkOutput("mid_rst_pending", {8'd0, pending}, 16'h0000);
    checkOutput("mid_rst_ready", {15'd0, res_ready}, 16'h0001);

    // two queued A writes behind a pair: youngest value forwards
    fwd_sel = 3'd7;
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h7788);
    step();
    applyStimulus(1'b1, 1'b0, 3'd7, 16'h0011);
    step();
    applyStimulus(1'b1, 1'b0, 3'd7, 16'h0022);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
`ifdef WB_FWD_EN
    checkOutput("fwd_young", {7'd0, fwd_hit, fwd_data}, 16'h0122);
`else
    checkOutput("fwd_off", {7'd0, fwd_hit, fwd_data}, 16'h0000);
`endif
    repeat (2) step();

    fwd_sel = 3'd6;
    applyStimulus(1'b1, 1'b1, 3'd3, 16'h00CD);
    step();
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
`ifdef WB_FWD_EN
    checkOutput("fwd_f_mask", {7'd0, fwd_hit, fwd_data}, 16'h01C0);
`else
    checkOutput("fwd_f_off", {7'd0, fwd_hit, fwd_data}, 16'h0000);
`endif
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
